// File: rtl/irrigation_zone_scheduler.sv
// rtl/irrigation_zone_scheduler.sv - round-robin shared-pump scheduler across irrigation zones
// Grants the pump to Dry zones in turn, with valve prime, min/max on-time and cooldown in slow ticks.
module irrigation_zone_scheduler #(
  parameter int NUM_ZONES      = 4,
  parameter int ZW             = 2,
  parameter int CNT_W          = 8,
  parameter int MIN_ON_TICKS   = 4,
  parameter int MAX_ON_TICKS   = 20,
  parameter int COOLDOWN_TICKS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 cls_valid,
  input  logic [ZW-1:0]        cls_zone,
  input  logic [1:0]           cls_class,
  output logic                 pump,
  output logic [NUM_ZONES-1:0] valve,
  output logic [ZW-1:0]        active_zone,
  output logic                 busy,
  output logic                 timeout,
  output logic [NUM_ZONES-1:0] req_pending
);

  typedef enum logic [1:0] {IDLE, PRIME, WATER, COOL} state_t;

  localparam logic [CNT_W-1:0]     MIN_C    = CNT_W'(MIN_ON_TICKS);
  localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_ON_TICKS);
  localparam logic [CNT_W-1:0]     COOL_C   = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [ZW-1:0]        ZONE_ONE = ZW'(1);
  localparam logic [NUM_ZONES-1:0] VALVE0   = NUM_ZONES'(1);

  state_t                 state_q, state_d;
  logic [NUM_ZONES-1:0]   req_q, req_d;
  logic [ZW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ZW-1:0]          active_zone_q, active_zone_d;
  logic [CNT_W-1:0]       on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0]       cool_cnt_q, cool_cnt_d;

  logic                   grant_found;
  logic [ZW-1:0]          grant_zone;
  logic                   max_hit;
  logic                   done_early;

  assign max_hit    = (state_q == WATER) && (on_cnt_q == MAX_C);
  assign done_early = (state_q == WATER) && !req_q[active_zone_q] && (on_cnt_q >= MIN_C);

  // Walk from the highest offset down so the nearest set bit at/after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_zone  = rr_ptr_q;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (req_q[rr_ptr_q + ZW'(i)]) begin
        grant_found = 1'b1;
        grant_zone  = rr_ptr_q + ZW'(i);
      end
    end
  end

  // A timeout clear of the active zone overrides a same-cycle Dry report.
  always_comb begin
    req_d = req_q;
    if (cls_valid) begin
      case (cls_class)
        2'b00:   req_d[cls_zone] = 1'b1;
        2'b01,
        2'b10:   req_d[cls_zone] = 1'b0;
        default: req_d = req_q;
      endcase
    end
    if (max_hit) begin
      req_d[active_zone_q] = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    active_zone_d = active_zone_q;
    on_cnt_d      = on_cnt_q;
    cool_cnt_d    = cool_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          active_zone_d = grant_zone;
          state_d       = PRIME;
        end
      end
      PRIME: begin
        on_cnt_d = '0;
        state_d  = WATER;
      end
      WATER: begin
        if (max_hit || done_early) begin
          cool_cnt_d = '0;
          state_d    = COOL;
        end else if (tick) begin
          on_cnt_d = on_cnt_q + CNT_ONE;
        end
      end
      COOL: begin
        if (cool_cnt_q == COOL_C) begin
          rr_ptr_d = active_zone_q + ZONE_ONE;
          state_d  = IDLE;
        end else if (tick) begin
          cool_cnt_d = cool_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_q         <= '0;
      rr_ptr_q      <= '0;
      active_zone_q <= '0;
      on_cnt_q      <= '0;
      cool_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      rr_ptr_q      <= rr_ptr_d;
      active_zone_q <= active_zone_d;
      on_cnt_q      <= on_cnt_d;
      cool_cnt_q    <= cool_cnt_d;
    end
  end

  // Outputs decode straight from registered state so reset drops them immediately.
  assign pump        = (state_q == WATER);
  assign valve       = ((state_q == PRIME) || (state_q == WATER)) ? (VALVE0 << active_zone_q) : '0;
  assign active_zone = active_zone_q;
  assign busy        = (state_q != IDLE);
  assign timeout     = max_hit;
  assign req_pending = req_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb/tb_irrigation_zone_scheduler.sv - self-checking bench for irrigation_zone_scheduler
module tb_irrigation_zone_scheduler;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       cls_valid;
  logic [1:0] cls_zone;
  logic [1:0] cls_class;
  logic       pump;
  logic [3:0] valve;
  logic [1:0] active_zone;
  logic       busy;
  logic       timeout;
  logic [3:0] req_pending;

  irrigation_zone_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .cls_valid   (cls_valid),
    .cls_zone    (cls_zone),
    .cls_class   (cls_class),
    .pump        (pump),
    .valve       (valve),
    .active_zone (active_zone),
    .busy        (busy),
    .timeout     (timeout),
    .req_pending (req_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] z;
    logic [1:0] c;
    logic [3:0] exp_req;
  } vec_t;

  vec_t     tbl[11];
  int       n_checks;
  int       n_fail;
  logic [1:0] sb_q[$];
  logic     sb_en;
  logic     prev_pump;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; also runs the pump/valve invariant and the grant scoreboard.
  task automatic step();
    logic [1:0] exp_zone;
    logic [3:0] exp_valve;
    @(posedge clk);
    #1;
    if (pump) chk("pump_onehot_valve", 32'($onehot(valve)), 32'd1);
    if (pump && !prev_pump && sb_en) begin
      if (sb_q.size() == 0) begin
        chk("grant_unexpected", 32'd1, 32'd0);
      end else begin
        exp_zone  = sb_q.pop_front();
        exp_valve = 4'b0001 << exp_zone;
        chk("grant_zone", 32'(active_zone), 32'(exp_zone));
        chk("grant_valve", 32'(valve), 32'(exp_valve));
      end
    end
    prev_pump = pump;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic send(input logic [1:0] z, input logic [1:0] c);
    cls_valid = 1'b1;
    cls_zone  = z;
    cls_class = c;
    step();
    cls_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    tick      = 1'b0;
    cls_valid = 1'b0;
    cls_zone  = 2'd0;
    cls_class = 2'd0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    prev_pump = 1'b0;
  endtask

  task automatic wait_pump();
    for (int i = 0; i < 10 && !pump; i++) step();
    chk("wait_pump", 32'(pump), 32'd1);
  endtask

  task automatic serve(input logic [1:0] z, input logic re, input logic [1:0] rz);
    wait_pump();
    send(z, 2'b01);
    if (re) begin
      sb_q.push_back(rz);
      send(rz, 2'b00);
    end
    for (int i = 0; i < 40 && busy; i++) begin
      do_tick();
      step();
    end
    chk("serve_done", 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    sb_en     = 1'b0;
    prev_pump = 1'b0;
    tbl[0]  = '{1'b1, 2'd2, 2'b00, 4'b0100};
    tbl[1]  = '{1'b1, 2'd0, 2'b00, 4'b0101};
    tbl[2]  = '{1'b1, 2'd2, 2'b11, 4'b0101};
    tbl[3]  = '{1'b1, 2'd0, 2'b01, 4'b0100};
    tbl[4]  = '{1'b1, 2'd3, 2'b00, 4'b1100};
    tbl[5]  = '{1'b0, 2'd3, 2'b01, 4'b1100};
    tbl[6]  = '{1'b1, 2'd2, 2'b10, 4'b1000};
    tbl[7]  = '{1'b1, 2'd1, 2'b00, 4'b1010};
    tbl[8]  = '{1'b1, 2'd3, 2'b11, 4'b1010};
    tbl[9]  = '{1'b1, 2'd1, 2'b01, 4'b1000};
    tbl[10] = '{1'b1, 2'd3, 2'b10, 4'b0000};

    rst_n     = 1'b0;
    tick      = 1'b0;
    cls_valid = 1'b0;
    cls_zone  = 2'd0;
    cls_class = 2'd0;
    #2;
    chk("rst_pump", 32'(pump), 32'd0);
    chk("rst_valve", 32'(valve), 32'd0);
    chk("rst_zone", 32'(active_zone), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_req", 32'(req_pending), 32'd0);
    do_reset();

    // Request register vectors (no ticks, so no watering ever ends here).
    for (int i = 0; i < 11; i++) begin
      cls_valid = tbl[i].v;
      cls_zone  = tbl[i].z;
      cls_class = tbl[i].c;
      step();
      cls_valid = 1'b0;
      chk($sformatf("req_vec%0d", i), 32'(req_pending), 32'(tbl[i].exp_req));
    end

    // Single zone with early clear.
    do_reset();
    sb_en = 1'b1;
    sb_q.push_back(2'd2);
    send(2'd2, 2'b00);
    chk("a_req", 32'(req_pending), 32'b0100);
    chk("a_idle_valve", 32'(valve), 32'd0);
    step();
    chk("a_prime_valve", 32'(valve), 32'b0100);
    chk("a_prime_pump", 32'(pump), 32'd0);
    chk("a_prime_busy", 32'(busy), 32'd1);
    step();
    chk("a_water_pump", 32'(pump), 32'd1);
    do_tick();
    step();
    send(2'd2, 2'b01);
    chk("a_cleared_req", 32'(req_pending), 32'd0);
    chk("a_min_hold1", 32'(pump), 32'd1);
    do_tick();
    step();
    do_tick();
    step();
    chk("a_min_hold3", 32'(pump), 32'd1);
    do_tick();
    chk("a_min_hold4", 32'(pump), 32'd1);
    step();
    chk("a_cool_pump", 32'(pump), 32'd0);
    chk("a_cool_valve", 32'(valve), 32'd0);
    chk("a_cool_busy", 32'(busy), 32'd1);
    do_tick();
    step();
    do_tick();
    step();
    do_tick();
    chk("a_cool_busy3", 32'(busy), 32'd1);
    step();
    chk("a_idle_busy", 32'(busy), 32'd0);
    chk("a_no_timeout", 32'(timeout), 32'd0);

    // Round-robin with a re-assert of zone 0 while zone 1 waters.
    do_reset();
    sb_q.push_back(2'd0);
    sb_q.push_back(2'd1);
    sb_q.push_back(2'd3);
    send(2'd0, 2'b00);
    send(2'd1, 2'b00);
    send(2'd3, 2'b00);
    serve(2'd0, 1'b0, 2'd0);
    serve(2'd1, 1'b1, 2'd0);
    serve(2'd3, 1'b0, 2'd0);
    serve(2'd0, 1'b0, 2'd0);
    chk("rr_all_served", 32'(sb_q.size()), 32'd0);
    chk("rr_req_empty", 32'(req_pending), 32'd0);

    // Timeout with a same-cycle Dry report for the timed-out zone.
    do_reset();
    sb_q.push_back(2'd1);
    send(2'd1, 2'b00);
    wait_pump();
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      if (k < 20) begin
        chk($sformatf("t_on_%0d", k), 32'({pump, timeout}), 32'b10);
        step();
      end
    end
    chk("t_timeout_pulse", 32'({pump, timeout}), 32'b11);
    send(2'd1, 2'b00);
    chk("t_timeout_end", 32'(timeout), 32'd0);
    chk("t_pump_off", 32'(pump), 32'd0);
    chk("t_req_cleared", 32'(req_pending), 32'd0);
    chk("t_cool_busy", 32'(busy), 32'd1);
    do_tick();
    step();
    do_tick();
    step();
    do_tick();
    chk("t_cool_busy3", 32'(busy), 32'd1);
    step();
    chk("t_idle", 32'(busy), 32'd0);
    repeat (4) step();
    chk("t_no_regrant_busy", 32'(busy), 32'd0);
    chk("t_no_regrant_valve", 32'(valve), 32'd0);

    // Reserved class on the active zone, then asynchronous reset mid-water.
    do_reset();
    sb_q.push_back(2'd0);
    send(2'd0, 2'b00);
    wait_pump();
    do_tick();
    step();
    send(2'd0, 2'b11);
    chk("r_req_kept", 32'(req_pending), 32'b0001);
    chk("r_pump_kept", 32'(pump), 32'd1);
    chk("r_valve_kept", 32'(valve), 32'b0001);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_pump", 32'(pump), 32'd0);
    chk("ar_valve", 32'(valve), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_req", 32'(req_pending), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    prev_pump = 1'b0;
    repeat (5) step();
    chk("ar_stay_idle", 32'({busy, valve}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
